// File: rtl/rr_dispatch_if.sv
// Handshake bundle for rr_dispatch: upstream request/payload, downstream
// per-server ready/request/accept, and the held payload with its locked target.
interface rr_dispatch_if #(
    parameter int N = 8,
    parameter int W = 8
);
    localparam int TW = (N > 1) ? $clog2(N) : 1;

    logic          req_i;
    logic [W-1:0]  data_i;
    logic          ack_i;
    logic [N-1:0]  rdy_o;
    logic [N-1:0]  req_o;
    logic [W-1:0]  data_o;
    logic [N-1:0]  ack_o;
    logic [TW-1:0] tgt_o;
    logic          busy;

    // Environment side: upstream requester plus the downstream servers.
    modport master (
        output req_i, data_i, rdy_o, ack_o,
        input  ack_i, req_o, data_o, tgt_o, busy
    );

    // Dispatcher side.
    modport slave (
        input  req_i, data_i, rdy_o, ack_o,
        output ack_i, req_o, data_o, tgt_o, busy
    );
endinterface

// File: rtl/rr_dispatch.sv
// Round-robin dispatcher: takes one payload at a time from upstream and hands it
// to one of N ready servers, rotating priority past the last server served.
module rr_dispatch #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_dispatch_if.slave  bus
);
    localparam int TW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;

    logic [1:0]    state_reg;
    logic [N-1:0]  prio_reg;
    logic [N-1:0]  req_reg;
    logic [W-1:0]  data_reg;
    logic [TW-1:0] tgt_reg;
    logic          busy_reg;

    logic [TW-1:0] prio_idx;
    logic [TW-1:0] sel_idx;
    logic [TW:0]   scan_pos;
    logic [N-1:0]  sel_onehot;
    logic          tgt_ack;

    always_comb begin
        prio_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (prio_reg[i]) prio_idx = TW'(i);
        end
    end

    // Walk offsets from the highest down so the ready server closest to prio wins.
    always_comb begin
        sel_idx  = '0;
        scan_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_pos = {1'b0, prio_idx} + (TW+1)'(k);
            if (scan_pos >= (TW+1)'(N)) scan_pos = scan_pos - (TW+1)'(N);
            if (bus.rdy_o[scan_pos[TW-1:0]]) sel_idx = scan_pos[TW-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel_dec
            assign sel_onehot[gi] = (sel_idx == TW'(gi));
        end
    endgenerate

    assign tgt_ack    = bus.ack_o[tgt_reg];
    assign bus.ack_i  = (state_reg == ST_IDLE);
    assign bus.req_o  = req_reg;
    assign bus.data_o = data_reg;
    assign bus.tgt_o  = tgt_reg;
    assign bus.busy   = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            prio_reg  <= N'(1);
            req_reg   <= '0;
            data_reg  <= '0;
            tgt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        data_reg  <= bus.data_i;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (|bus.rdy_o) begin
                        tgt_reg   <= sel_idx;
                        req_reg   <= sel_onehot;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Only the locked server's accept completes; rdy_o no longer matters.
                    if (tgt_ack) begin
                        prio_reg  <= {req_reg[N-2:0], req_reg[N-1]};
                        req_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_dispatch.sv
// Self-checking bench for rr_dispatch (N=4): table-driven dispatch vectors with a
// completion scoreboard, plus hand-written stall, ack-filter and reset sequences.
module tb_rr_dispatch;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_dispatch_if #(.N(N), .W(W)) bus();
    rr_dispatch #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic         req_v;
    logic [W-1:0] data_v;
    logic [N-1:0] rdy_v;
    logic [N-1:0] ack_man;
    logic         mirror;

    assign bus.req_i  = req_v;
    assign bus.data_i = data_v;
    assign bus.rdy_o  = rdy_v;
    assign bus.ack_o  = mirror ? bus.req_o : ack_man;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   tgt;
    } exp_t;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] rdy;
        int           tgt;
        bit           gap;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   cyc     = 0;
    int   acc;
    int   last_acc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // A downstream transfer completes on any cycle where the target's request meets its accept.
    always @(negedge clk) begin
        if (!rst && ((bus.req_o & bus.ack_o) != '0)) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_completion: got tgt %0d, expected none", bus.tgt_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] completion data=0x%02h tgt=%0d req_o=%b", bus.data_o, bus.tgt_o, bus.req_o);
                check("sb_tgt", int'(bus.tgt_o), int'(mon_e.tgt));
                check("sb_data", int'(bus.data_o), int'(mon_e.data));
                check("sb_req_onehot", int'(bus.req_o), 1 << mon_e.tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [N-1:0] rdy, input int tgt,
                        output int acc_cyc);
        int waited = 0;
        acc_cyc = -1;
        data_v  = d;
        req_v   = 1'b1;
        while (!bus.ack_i && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.ack_i) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ack_i got 0, expected 1");
        end else begin
            rdy_v   = rdy;
            acc_cyc = cyc;
            exp_q.push_back(exp_t'{data: d, tgt: 2'(tgt)});
        end
        tick();
        req_v = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (!bus.ack_i && waited < 50) begin
            tick();
            waited++;
        end
        check("drain_idle", int'(bus.ack_i), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h11, 4'b1111, 0, 1'b0};
        vecs[1] = '{8'h22, 4'b1111, 1, 1'b1};
        vecs[2] = '{8'h33, 4'b1111, 2, 1'b1};
        vecs[3] = '{8'h44, 4'b1111, 3, 1'b1};
        vecs[4] = '{8'h55, 4'b1111, 0, 1'b1};
        vecs[5] = '{8'h66, 4'b1001, 3, 1'b1};
        vecs[6] = '{8'h77, 4'b0110, 1, 1'b1};

        rst = 1'b1; req_v = 1'b0; data_v = '0; rdy_v = '0; ack_man = '0; mirror = 1'b1;
        tick();
        tick();
        check("rst_ack_i", int'(bus.ack_i), 1);
        check("rst_req_o", int'(bus.req_o), 0);
        check("rst_data_o", int'(bus.data_o), 0);
        check("rst_tgt_o", int'(bus.tgt_o), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;

        // Back-to-back rotation, wrap and skip over non-ready servers.
        last_acc = 0;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].data, vecs[i].rdy, vecs[i].tgt, acc);
            $display("[TB] accept data=0x%02h rdy=%b cycle=%0d", vecs[i].data, vecs[i].rdy, acc);
            if (vecs[i].gap) check("ack_i_gap", acc - last_acc, 3);
            last_acc = acc;
        end
        drain();

        // Stall in SELECT with no ready server, then release server 2.
        send(8'h88, 4'b0000, 2, acc);
        for (int i = 0; i < 10; i++) begin
            check("stall_req_o", int'(bus.req_o), 0);
            check("stall_ack_i", int'(bus.ack_i), 0);
            check("stall_busy", int'(bus.busy), 1);
            tick();
        end
        rdy_v = 4'b0100;
        tick();
        check("stall_release_req_o", int'(bus.req_o), 4'b0100);
        drain();

        // Locked target ignores rdy_o changes and non-target accepts.
        mirror = 1'b0; ack_man = '0;
        send(8'h99, 4'b0100, 2, acc);
        tick();
        check("lock_req_o", int'(bus.req_o), 4'b0100);
        rdy_v = 4'b0000; ack_man = 4'b1001;
        tick();
        tick();
        check("filter_req_o", int'(bus.req_o), 4'b0100);
        check("filter_busy", int'(bus.busy), 1);
        check("filter_ack_i", int'(bus.ack_i), 0);
        check("filter_data_o", int'(bus.data_o), 8'h99);
        ack_man = 4'b1101;
        tick();
        check("filter_done_ack_i", int'(bus.ack_i), 1);
        check("filter_done_req_o", int'(bus.req_o), 0);
        check("filter_done_busy", int'(bus.busy), 0);
        ack_man = '0; mirror = 1'b1;
        send(8'hAA, 4'b1111, 3, acc);
        drain();
        send(8'hB0, 4'b0100, 2, acc);
        drain();

        // Reset while issuing to server 1 drops the payload and restores prio.
        mirror = 1'b0;
        send(8'hBB, 4'b0010, 1, acc);
        tick();
        check("pre_rst_req_o", int'(bus.req_o), 4'b0010);
        check("pre_rst_tgt_o", int'(bus.tgt_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_req_o", int'(bus.req_o), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_ack_i", int'(bus.ack_i), 1);
        check("mid_rst_data_o", int'(bus.data_o), 0);
        mirror = 1'b1;
        send(8'hCC, 4'b1111, 0, acc);
        drain();

        check("completions", n_done, 12);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
